// File: rtl/inbuf_vc_cell.sv
// Receive-side input buffer for one router port: two single-entry VC slots,
// one written from the upstream link while the other is offered to the switch.
module inbuf_vc_cell #(
  parameter int unsigned DW     = 64,
  parameter int unsigned VC_BIT = 63
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          polarity,
  input  logic          si,
  input  logic [DW-1:0] di,
  output logic          ri,
  output logic          req,
  output logic [DW-1:0] dout,
  input  logic          gnt,
  output logic [1:0]    full,
  output logic          ovf_err,
  output logic          vc_err
);

  logic          ext_vc;
  logic          int_vc;
  logic          wr_en;
  logic          tag_bad;
  logic          ovf;
  logic          drain;
  logic [1:0]    full_nxt;
  logic [DW-1:0] slot0;
  logic [DW-1:0] slot1;

  // Link/switch side selection and handshake decode
  always_comb begin
    ext_vc  = polarity;
    int_vc  = ~polarity;
    ri      = ~full[ext_vc];
    req     = full[int_vc];
    dout    = '0;
    if (req) dout = int_vc ? slot1 : slot0;
    wr_en   = si & ri & (di[VC_BIT] == ext_vc);
    tag_bad = si & ri & (di[VC_BIT] != ext_vc);
    ovf     = si & ~ri;
    drain   = req & gnt;
  end

  // Occupancy update: write and drain always hit different slots
  always_comb begin
    full_nxt = full;
    if (wr_en) full_nxt[ext_vc] = 1'b1;
    if (drain) full_nxt[int_vc] = 1'b0;
  end

  // Slot storage, occupancy and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      full    <= 2'b00;
      slot0   <= '0;
      slot1   <= '0;
      ovf_err <= 1'b0;
      vc_err  <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_en && !ext_vc) slot0 <= di;
      if (wr_en &&  ext_vc) slot1 <= di;
      if (ovf)     ovf_err <= 1'b1;
      if (tag_bad) vc_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inbuf_vc_cell.sv
// Self-checking bench for inbuf_vc_cell: per-VC scoreboard queues filled on
// accepted writes and popped when the switch side grants a flit.
module tb_inbuf_vc_cell;

  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          polarity;
  logic          si;
  logic [DW-1:0] di;
  logic          ri;
  logic          req;
  logic [DW-1:0] dout;
  logic          gnt;
  logic [1:0]    full;
  logic          ovf_err;
  logic          vc_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic          m_ovf = 1'b0;
  logic          m_vc  = 1'b0;

  inbuf_vc_cell #(.DW(DW), .VC_BIT(63)) dut (
    .clk(clk), .reset(reset), .polarity(polarity), .si(si), .di(di),
    .ri(ri), .req(req), .dout(dout), .gnt(gnt), .full(full),
    .ovf_err(ovf_err), .vc_err(vc_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int qn(input logic v);
    return v ? q1.size() : q0.size();
  endfunction

  // Post-edge registered state against the model
  task automatic check_state(input string tag);
    check({tag, "_full"}, DW'({q1.size() != 0, q0.size() != 0}), DW'(2'b0) | DW'({q1.size() != 0, q0.size() != 0}) == 0 ? '0 : DW'({q1.size() != 0, q0.size() != 0}));
    check({tag, "_ovf"}, DW'(ovf_err), DW'(m_ovf));
    check({tag, "_vcerr"}, DW'(vc_err), DW'(m_vc));
  endtask

  // One clock: drive at negedge, check Mealy outputs, update model, check state
  task automatic step(input logic p, input logic s, input logic [DW-1:0] d,
                      input logic g, input logic r);
    logic ev;
    logic iv;
    logic acc;
    logic [DW-1:0] exp_flit;
    @(negedge clk);
    polarity = p; si = s; di = d; gnt = g; reset = r;
    #1;
    ev = p;
    iv = ~p;
    check("ri", DW'(ri), DW'(qn(ev) == 0));
    check("req", DW'(req), DW'(qn(iv) != 0));
    if (qn(iv) == 0) check("dout_idle", dout, '0);
    if (r) begin
      q0.delete();
      q1.delete();
      m_ovf = 1'b0;
      m_vc  = 1'b0;
    end else begin
      if (g && qn(iv) != 0) begin
        exp_flit = iv ? q1.pop_front() : q0.pop_front();
        check("dout_gnt", dout, exp_flit);
      end
      acc = s && (qn(ev) == 0);
      if (acc && d[63] == ev) begin
        if (ev) q1.push_back(d); else q0.push_back(d);
      end
      if (acc && d[63] != ev) m_vc = 1'b1;
      if (s && !acc) m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    check("full", DW'(full), DW'({q1.size() != 0, q0.size() != 0}));
    check("ovf_err", DW'(ovf_err), DW'(m_ovf));
    check("vc_err", DW'(vc_err), DW'(m_vc));
  endtask

  initial begin
    logic p;
    logic s;
    logic g;
    logic tag;
    logic [DW-1:0] d;

    reset = 1'b1; polarity = 1'b0; si = 1'b0; di = '0; gnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ri", DW'(ri), DW'(1'b1));
    check("rst_req", DW'(req), DW'(1'b0));
    check("rst_dout", dout, '0);
    check("rst_full", DW'(full), DW'(2'b00));
    check("rst_ovf", DW'(ovf_err), DW'(1'b0));
    check("rst_vc", DW'(vc_err), DW'(1'b0));

    // Basic write to VC0 then drain at the opposite polarity
    step(1'b0, 1'b1, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0);
    check("t2_full01", DW'(full), DW'(2'b01));
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);

    // Overflow on a held VC0 slot, then concurrent VC1 write and VC0 drain
    step(1'b0, 1'b1, 64'h0000_0000_1234_5678, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'h1, 1'b0, 1'b0);
    check("t3_ovf", DW'(ovf_err), DW'(1'b1));
    step(1'b1, 1'b1, 64'h8000_0000_0000_00AA, 1'b1, 1'b0);
    check("t4_full10", DW'(full), DW'(2'b10));
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Wrong VC tag is dropped and flagged
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'h8000_0000_0000_0001, 1'b0, 1'b0);
    check("t5_vc", DW'(vc_err), DW'(1'b1));
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Fill both VCs, then reset overrides traffic
    step(1'b1, 1'b1, 64'h8000_0000_0000_00BB, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'h0000_0000_0000_00CC, 1'b0, 1'b0);
    check("t6_full11", DW'(full), DW'(2'b11));
    step(1'b1, 1'b1, 64'h8000_0000_0000_00DD, 1'b1, 1'b1);
    check("t6_full00", DW'(full), DW'(2'b00));
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);

    // Random traffic with toggling polarity and a mid-run reset
    p = 1'b0;
    for (int i = 0; i < 300; i++) begin
      s   = 1'($urandom_range(0, 1));
      g   = 1'($urandom_range(0, 1));
      tag = ($urandom_range(0, 9) == 0) ? ~p : p;
      d   = {tag, 31'($urandom), 32'($urandom)};
      step(p, s, d, g, (i == 150) ? 1'b1 : 1'b0);
      p = ~p;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
